// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, sizes and helpers for the 4-way round-robin arbiter
//
// Purpose : common definitions imported by rr_pick_4 and rr_arbiter_4_way.
// Contents: N_REQ / SEL_W sizes, state_t FSM encoding, onehot4() decoder.

package arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - rotating-priority first-set-bit finder over 4 requests
//
// Purpose : combinational search for the first set request bit, starting at
//           ptr and wrapping around modulo 4.
// Ports   : req   [3:0] in  - request vector
//           ptr   [1:0] in  - highest-priority index this round
//           found       out - any request set
//           idx   [1:0] out - winning index (equals ptr when nothing found)

module rr_pick_4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            // SEL_W-bit addition wraps naturally, giving the modulo-4 rotation.
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4_way.sv
// rtl/rr_arbiter_4_way.sv - round-robin 4-way arbiter with bounded grant hold
//
// Purpose : grants one of four level requesters ownership of a shared path,
//           holds the grant for the whole transaction up to MAX_HOLD cycles,
//           and inserts one turnaround cycle between owners.
// Ports   : clk            in  - rising-edge clock
//           reset_n        in  - synchronous active-low reset
//           req    [3:0]   in  - level request per requester
//           grant  [3:0]   out - registered one-hot or zero grant
//           select [1:0]   out - index of current/last owner (steering select)
//           busy           out - high while a grant is asserted

module rr_arbiter_4_way
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] select,
    output logic             busy
);

    state_t            state;
    logic [SEL_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;

    logic              owner_req;
    logic              hold_done;

    rr_pick_4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // select always names the current owner while in GRANT.
    assign owner_req = req[select];
    assign hold_done = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            select   <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (pick_found) begin
                        state    <= GRANT;
                        grant    <= onehot4(pick_idx);
                        select   <= pick_idx;
                        busy     <= 1'b1;
                        hold_cnt <= HOLD_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!owner_req || hold_done) begin
                        // select is left alone so the datapath stays steered
                        // at the last owner through the turnaround.
                        state <= TURN;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= select + SEL_W'(1);
                    end else if (hold_cnt != {HOLD_W{1'b1}}) begin
                        // Saturating so an unlimited hold never wraps.
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4_way.sv
// tb/tb_rr_arbiter_4_way.sv - self-checking bench for rr_arbiter_4_way

module tb_rr_arbiter_4_way;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] grant8, grant0;
    logic [1:0] select8, select0;
    logic       busy8, busy0;

    logic       use0 = 1'b0;
    logic [3:0] act_grant;
    logic [1:0] act_select;
    logic       act_busy;

    logic       dm_a, dm_b, dm_c, dm_d;

    int checks = 0;
    int failures = 0;

    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    rr_arbiter_4_way #(.MAX_HOLD(8), .HOLD_W(4)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant8),
        .select  (select8),
        .busy    (busy8)
    );

    rr_arbiter_4_way #(.MAX_HOLD(0), .HOLD_W(4)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant0),
        .select  (select0),
        .busy    (busy0)
    );

    assign act_grant  = use0 ? grant0  : grant8;
    assign act_select = use0 ? select0 : select8;
    assign act_busy   = use0 ? busy0   : busy8;

    // dmux_4_way with in = 1 steered by select
    assign dm_a = (act_select == 2'd0);
    assign dm_b = (act_select == 2'd1);
    assign dm_c = (act_select == 2'd2);
    assign dm_d = (act_select == 2'd3);

    function automatic vec_t mk(input logic r, input logic [3:0] q,
                                input logic [3:0] g, input logic [1:0] s,
                                input logic b);
        vec_t v;
        v.rst_n = r;
        v.req   = q;
        v.grant = g;
        v.sel   = s;
        v.busy  = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic [3:0] eg,
                        input logic [1:0] es, input logic eb, input string name);
        exp_t e;
        reset_n = r;
        req     = q;
        sb.push_back('{grant: eg, sel: es, busy: eb});
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk({name, ".grant"},  {4'd0, act_grant},  {4'd0, e.grant});
        chk({name, ".select"}, {6'd0, act_select}, {6'd0, e.sel});
        chk({name, ".busy"},   {7'd0, act_busy},   {7'd0, e.busy});
        if (e.busy)
            chk({name, ".dmux"}, {4'd0, dm_d, dm_c, dm_b, dm_a}, {4'd0, e.grant});
        chk({name, ".onehot0"}, {7'd0, $onehot0(act_grant)}, 8'd1);
        chk({name, ".busy_or"}, {7'd0, act_busy}, {7'd0, |act_grant});
        if (act_busy)
            chk({name, ".grant_sel"}, {7'd0, act_grant[act_select]}, 8'd1);
    endtask

    initial begin
        // Reset and basic arbitration, then single requester, handover, mid-grant reset.
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1));
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1));
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0));
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0));
        vecs.push_back(mk(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1));
        vecs.push_back(mk(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1));
        vecs.push_back(mk(1'b1, 4'b1000, 4'b0000, 2'd1, 1'b0));
        vecs.push_back(mk(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1));
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0));
        vecs.push_back(mk(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1));
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0));
        vecs.push_back(mk(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1));
        vecs.push_back(mk(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1));
        vecs.push_back(mk(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1));

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst_n, vecs[i].req, vecs[i].grant, vecs[i].sel, vecs[i].busy,
                 $sformatf("vec%0d", i));

        // Full contention with MAX_HOLD = 8: 8-cycle grants, 1-cycle gaps, rotation.
        step(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, "cont_rst");
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 8; k++)
                step(1'b1, 4'b1111, 4'b0001 << (g % 4), 2'(g % 4), 1'b1,
                     $sformatf("cont_g%0d_c%0d", g, k));
            step(1'b1, 4'b1111, 4'b0000, 2'(g % 4), 1'b0, $sformatf("cont_gap%0d", g));
        end

        // Owner drops req on the same edge its hold expires: single turnaround.
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "drop_rst");
        for (int k = 0; k < 8; k++)
            step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, $sformatf("drop_c%0d", k));
        step(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, "drop_turn");
        step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, "drop_new");

        // Unlimited hold instance: no preemption over 40 cycles.
        use0 = 1'b1;
        step(1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0, "unl_rst");
        for (int k = 0; k < 40; k++)
            step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, $sformatf("unl_c%0d", k));
        step(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, "unl_turn");
        step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, "unl_new");

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4_way.md
Name: rr_arbiter_4_way

Overview:
- Round-robin arbiter sharing one datapath resource between 4 requesters.
- Drives the 2-bit select of dmux_4_way (and its mux_4_way companion), so exactly one requester owns the shared path at a time.
- Grants are held for a whole transaction, bounded by a maximum hold time so no requester can starve the others.
- Sits between requesting units and the 4-way steering logic.

Parameters:
- MAX_HOLD, 8, max consecutive grant cycles per ownership; 0 = unlimited (release only on req drop).
- HOLD_W, 4, width of hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- req  input  4  request per requester, level; bit i = requester i
- grant  output  4  one-hot (or zero) grant, registered
- select  output  2  binary index of current/last owner; feeds dmux_4_way select
- busy  output  1  high while any grant asserted

Behaviour:
- Single clock. Reset is synchronous and active-low: sampled on the rising edge of clk while reset_n = 0.
- Reset values: state IDLE, grant 0000, select 00, busy 0, ptr 0, hold_cnt 0. Reset overrides everything, including mid-grant.
- States:
  - IDLE: no grant.
  - GRANT: one owner.
  - TURN: one-cycle turnaround with grant 0000.
- IDLE:
  - At the edge, if req != 0, pick the first set bit searching ptr, ptr+1, ... mod 4.
  - Next cycle: grant = onehot(winner), select = winner, busy = 1, hold_cnt = 1, go to GRANT.
  - If req == 0, stay in IDLE.
- Latency: req first high in cycle N → grant visible in cycle N+1. Outputs are registered; there is no combinational req→grant path.
- GRANT, at each edge:
  - If req[owner] = 0 → TURN.
  - Else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD → TURN (preempt).
  - Else stay in GRANT and increment hold_cnt.
  - Consequence: the owner keeps grant for exactly MAX_HOLD cycles when preempted.
- Entering TURN:
  - grant = 0000, busy = 0, ptr = owner+1 mod 4.
  - select keeps the last owner so the datapath stays stable.
- TURN:
  - Arbitrates exactly like IDLE, so a new grant appears the cycle after TURN.
  - If req == 0, go to IDLE.
- Release-to-grant gap is always exactly 1 idle cycle.
- A preempted owner still requesting competes at lowest priority (ptr has advanced past it).
- Simultaneous events:
  - Owner drops req in the same cycle another raises req → TURN, then grant to the new requester by rotation.
  - Owner drops req in the same cycle hold_cnt hits MAX_HOLD → single TURN; the owner is not regranted unless it requests again.
- Invariants, checked by assertions:
  - grant is one-hot or zero.
  - busy == |grant.
  - When busy = 1, grant[select] = 1.
- hold_cnt saturates when MAX_HOLD = 0, so it never wraps.

Decomposition:
- Package arb_pkg:
  - N_REQ = 4, SEL_W = 2.
  - typedef enum state_t {IDLE, GRANT, TURN}.
  - Function onehot4(sel) returning 4 bits.
- Sub-module rr_pick_4 (combinational): inputs req[3:0] and ptr[1:0]; outputs found and idx[1:0] (first set bit at or after ptr, with wrap-around).
- The top level holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
1. Reset: reset_n = 0 for 2 cycles with req = 1111 → grant 0000, select 00, busy 0. First cycle after release: still 0000 (arbitration edge). Next cycle: grant 0001, select 00.
2. Single requester: req = 0100 from cycle 0 held 5 cycles, then 0 → grant 0100 and select 10 in cycles 1–5, grant 0000 in cycle 6, stays IDLE.
3. Full contention, MAX_HOLD = 8, req = 1111 held → each grant lasts 8 cycles with 1 idle cycle between, sequence 0001, 0010, 0100, 1000, 0001. A dmux_4_way with in = 1 driven by select shows only output (a,b,c,d) = index high during each grant.
4. MAX_HOLD = 0, req = 0011 held 40 cycles → grant 0001 for all 40 cycles, no preemption. Drop req[0] → TURN, then grant 0010.
5. Handover: owner 1 drops req in the same cycle req[3] rises (req 0010 → 1000) → next cycle grant 0000, select stays 01. The cycle after: grant 1000, select 11.
6. Reset mid-grant: grant 0100 at hold_cnt = 3, reset_n = 0 for 1 cycle → next cycle grant 0000, select 00, ptr 0. With req = 1111, first new grant is 0001.
